// File: rtl/sipo_stream_if.sv
// Bundles the serial input, parallel FIFO output and status bus of sipo_stream.
// The master modport is the deserialiser side; slave is the consumer/driver side.
interface sipo_stream_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             cs;
  logic             sdi;
  logic [WIDTH-1:0] pdo_data;
  logic             pdo_valid;
  logic             pdo_ready;
  logic [LW-1:0]    fifo_level;
  logic             frame_done;
  logic             partial_err;
  logic             overflow;
  logic             ovf_clr;
  logic [CNT_W-1:0] frame_words;
  logic             parity_err;

  modport master (
    input  cs, sdi, pdo_ready, ovf_clr,
    output pdo_data, pdo_valid, fifo_level, frame_done, partial_err,
           overflow, frame_words, parity_err
  );

  modport slave (
    output cs, sdi, pdo_ready, ovf_clr,
    input  pdo_data, pdo_valid, fifo_level, frame_done, partial_err,
           overflow, frame_words, parity_err
  );
endinterface

// File: rtl/sipo_stream.sv
// CS-framed serial-to-parallel deserialiser into a DEPTH-word FIFO; word valid 1 cycle after its last bit,
// drops (sticky overflow) when full and unpopped. Even parity per word when SIPO_STREAM_PARITY_EN is defined.
module sipo_stream #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sipo_stream_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(WIDTH + 1);
`ifdef SIPO_STREAM_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t           r_state;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_frame_words;
  logic             r_frame_done;
  logic             r_partial_err;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic [CNT_W-1:0] w_fw_base;
  logic             w_last;
  logic             w_shift_en;
  logic             w_push_req;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_cs_fall;

  assign w_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], bus.sdi} : {bus.sdi, r_sr[WIDTH-1:1]};
  assign w_last  = bus.cs && (r_bit_cnt == BW'(LAST));

`ifdef SIPO_STREAM_PARITY_EN
  logic r_parity_err;
  logic w_par_bad;

  // The parity-bit edge carries no data; the word is already complete in r_sr.
  assign w_par_bad  = w_last && ((^r_sr) ^ bus.sdi);
  assign w_shift_en = bus.cs && !w_last;
  assign w_word     = r_sr;
  assign w_push_req = w_last && !w_par_bad;
`else
  assign w_shift_en = bus.cs;
  assign w_word     = w_shift;
  assign w_push_req = w_last;
`endif

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = (r_level != '0) && bus.pdo_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && w_full && !w_pop;
  assign w_cs_fall = (r_state == ST_ACTIVE) && !bus.cs;
  assign w_fw_base = ((r_state == ST_IDLE) && bus.cs) ? '0 : r_frame_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_sr          <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_level       <= '0;
      r_frame_words <= '0;
      r_frame_done  <= 1'b0;
      r_partial_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= bus.cs ? ST_ACTIVE : ST_IDLE;
      r_frame_done  <= w_cs_fall && (r_bit_cnt == '0);
      r_partial_err <= w_cs_fall && (r_bit_cnt != '0);

      if (!bus.cs) begin
        r_bit_cnt <= '0;
        if (r_state == ST_ACTIVE) r_sr <= '0;
      end else begin
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + BW'(1);
        if (w_shift_en) r_sr <= w_shift;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);

      // Saturating count; the frame-start clear and an accepted word never share an edge.
      if (w_push && (w_fw_base != '1)) r_frame_words <= w_fw_base + CNT_W'(1);
      else                             r_frame_words <= w_fw_base;

      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

`ifdef SIPO_STREAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_par_bad;
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.pdo_valid   = (r_level != '0);
  assign bus.pdo_data    = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.fifo_level  = r_level;
  assign bus.frame_done  = r_frame_done;
  assign bus.partial_err = r_partial_err;
  assign bus.overflow    = r_overflow;
  assign bus.frame_words = r_frame_words;
endmodule

// File: tb/tb_sipo_stream.sv
// Directed bench: an MSB-first instance and an LSB-first instance (2-bit frame counter) share one serial stimulus.
module tb_sipo_stream;
  logic clk;
  logic rst_n;
  logic cs, sdi, rdy, clr;
  int   n_pass, n_tot;

  sipo_stream_if #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) ifm ();
  sipo_stream_if #(.WIDTH(32), .DEPTH(4), .CNT_W(2))  ifl ();

  assign ifm.cs = cs;  assign ifm.sdi = sdi;  assign ifm.pdo_ready = rdy;  assign ifm.ovf_clr = clr;
  assign ifl.cs = cs;  assign ifl.sdi = sdi;  assign ifl.pdo_ready = rdy;  assign ifl.ovf_clr = clr;

  sipo_stream #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(ifm.master));
  sipo_stream #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0), .CNT_W(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(ifl.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_l;
  } vec_t;
  vec_t vecs[5];

  logic [31:0] ow[5];
  logic [31:0] sw[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drives the top n bits of w MSB-first, one per cycle, starting at the current falling edge.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) begin
      cs = 1'b1; sdi = w[i];
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
`ifdef SIPO_STREAM_PARITY_EN
    cs = 1'b1; sdi = ^w;
    @(negedge clk);
`endif
  endtask

  task automatic end_frame();
    cs = 1'b0; sdi = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    cs = 0; sdi = 0; rdy = 0; clr = 0; rst_n = 0;
    vecs[0] = '{32'hDEADBEEF, 32'hF77DB57B};
    vecs[1] = '{32'h00000001, 32'h80000000};
    vecs[2] = '{32'h01234567, 32'hE6A2C480};
    vecs[3] = '{32'h80000000, 32'h00000001};
    vecs[4] = '{32'hA5A5A5A5, 32'hA5A5A5A5};
    ow = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    sw = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};

    #3;
    check("rst_valid", ifm.pdo_valid, 0);
    check("rst_data", ifm.pdo_data, 0);
    check("rst_level", ifm.fifo_level, 0);
    check("rst_ovf", ifm.overflow, 0);
    check("rst_fw", ifm.frame_words, 0);
    check("rst_fd", ifm.frame_done, 0);
    check("rst_perr", ifm.partial_err, 0);
    check("rst_parerr", ifm.parity_err, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Two back-to-back words in one frame with the consumer always ready.
    rdy = 1;
    send_word(32'hDEADBEEF);
    check("s1_valid0", ifm.pdo_valid, 1);
    check("s1_data0", ifm.pdo_data, 32'hDEADBEEF);
    check("s1_data0_l", ifl.pdo_data, 32'hF77DB57B);
    send_word(32'h01234567);
    check("s1_valid1", ifm.pdo_valid, 1);
    check("s1_data1", ifm.pdo_data, 32'h01234567);
    end_frame();
    check("s1_fd", ifm.frame_done, 1);
    check("s1_fw", ifm.frame_words, 2);
    check("s1_empty", ifm.pdo_valid, 0);
    @(negedge clk);
    check("s1_fd_pulse", ifm.frame_done, 0);
    check("s1_fw_hold", ifm.frame_words, 2);
    rdy = 0;

    // Single-word frames through both bit orders.
    for (int k = 0; k < 5; k++) begin
      send_word(vecs[k].word);
      check("tbl_valid", ifm.pdo_valid, 1);
      check("tbl_level", ifm.fifo_level, 1);
      check("tbl_data_m", ifm.pdo_data, vecs[k].word);
      check("tbl_data_l", ifl.pdo_data, vecs[k].exp_l);
      rdy = 1;
      end_frame();
      rdy = 0;
      check("tbl_fd", ifm.frame_done, 1);
      check("tbl_fw", ifm.frame_words, 1);
      check("tbl_popped", ifm.pdo_valid, 0);
      check("tbl_parerr", ifm.parity_err, 0);
      @(negedge clk);
    end

    // cs drops after 20 bits.
    send_bits(32'hFFFFFFFF, 20);
    end_frame();
    check("part_perr", ifm.partial_err, 1);
    check("part_fd", ifm.frame_done, 0);
    check("part_level", ifm.fifo_level, 0);
    @(negedge clk);
    check("part_pulse", ifm.partial_err, 0);
    send_word(32'hCAFEF00D);
    check("part_next", ifm.pdo_data, 32'hCAFEF00D);
    rdy = 1;
    end_frame();
    rdy = 0;
    check("part_next_fd", ifm.frame_done, 1);
    @(negedge clk);

    // Five words into a four-deep FIFO with no consumer.
    for (int k = 0; k < 5; k++) send_word(ow[k]);
    end_frame();
    check("ovf_level", ifm.fifo_level, 4);
    check("ovf_set", ifm.overflow, 1);
    check("ovf_fw", ifm.frame_words, 4);
    check("ovf_fw_sat", ifl.frame_words, 3);
    rdy = 1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain", ifm.pdo_data, ow[k]);
      @(negedge clk);
    end
    rdy = 0;
    check("ovf_drained", ifm.pdo_valid, 0);
    check("ovf_sticky", ifm.overflow, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("ovf_clr", ifm.overflow, 0);

    // Full FIFO, fifth word completes on the same edge as a pop.
    for (int k = 0; k < 4; k++) send_word(sw[k]);
    check("sim_full", ifm.fifo_level, 4);
`ifdef SIPO_STREAM_PARITY_EN
    send_bits(sw[4], 32);
    cs = 1; sdi = ^sw[4];
`else
    send_bits(sw[4], 31);
    cs = 1; sdi = sw[4][0];
`endif
    rdy = 1;
    @(negedge clk);
    rdy = 0;
    check("sim_level", ifm.fifo_level, 4);
    check("sim_no_ovf", ifm.overflow, 0);
    end_frame();
    check("sim_fw", ifm.frame_words, 5);
    check("sim_fw_sat", ifl.frame_words, 3);
    rdy = 1;
    for (int k = 1; k < 5; k++) begin
      check("sim_drain", ifm.pdo_data, sw[k]);
      @(negedge clk);
    end
    rdy = 0;
    check("sim_empty", ifm.pdo_valid, 0);

`ifdef SIPO_STREAM_PARITY_EN
    send_bits(32'h00000003, 32);
    cs = 1; sdi = 1'b0;
    @(negedge clk);
    check("par_ok_data", ifm.pdo_data, 32'h00000003);
    check("par_ok_perr", ifm.parity_err, 0);
    send_bits(32'h00000003, 32);
    cs = 1; sdi = 1'b1;
    @(negedge clk);
    check("par_bad_perr", ifm.parity_err, 1);
    check("par_bad_level", ifm.fifo_level, 1);
    end_frame();
    check("par_fw", ifm.frame_words, 1);
    check("par_pulse", ifm.parity_err, 0);
    rdy = 1;
    @(negedge clk);
    rdy = 0;
`endif

    // Asynchronous reset mid-word with two words queued.
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    send_bits(32'hFFFFFFFF, 10);
    check("arst_pre_level", ifm.fifo_level, 2);
    #2 rst_n = 0;
    cs = 0; sdi = 0;
    #1;
    check("arst_valid", ifm.pdo_valid, 0);
    check("arst_data", ifm.pdo_data, 0);
    check("arst_level", ifm.fifo_level, 0);
    check("arst_fw", ifm.frame_words, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    check("arst_fd", ifm.frame_done, 0);
    check("arst_perr", ifm.partial_err, 0);
    check("arst_level2", ifm.fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sipo_stream.md
Name: sipo_stream

Overview:
- Parametrised successor to the single-word SIPO capture used on the ASCON SPI output path.
- Deserialises a chip-select-framed serial stream into WIDTH-bit words and buffers them in a DEPTH-entry FIFO with a valid/ready output handshake.
- Reports frame boundaries, partial words and overflow.
- Sits between the ascon_spi serial output (sdo/valid) and any parallel consumer: checker, UART bridge or bench scoreboard.

Parameters:
- WIDTH, 32, bits per word (2..64).
- DEPTH, 4, FIFO entries; power of two, 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
- CNT_W, 16, width of the per-frame word counter.

Ports:
- clk  in  1  single clock; sdi and cs sampled on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  active-high frame enable; bits are captured only while high.
- sdi  in  1  serial data.
- pdo_data  out  WIDTH  FIFO head word.
- pdo_valid  out  1  FIFO non-empty.
- pdo_ready  in  1  consumer accepts head when pdo_valid=1.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- frame_done  out  1  one-cycle pulse on a clean frame end.
- partial_err  out  1  one-cycle pulse when cs falls mid-word.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.
- frame_words  out  CNT_W  words accepted in the current or last frame; saturating.
- parity_err  out  1  one-cycle pulse on bad parity; see Optional Feature.

Behaviour:
- Reset (rst_n=0, async): bit counter=0, shift register=0, FIFO empty, pdo_valid=0, pdo_data=0, fifo_level=0, frame_done=0, partial_err=0, overflow=0, frame_words=0, parity_err=0.
- Capture: each rising edge with cs=1 shifts sdi into the shift register and increments the bit counter (0..WIDTH-1).
  - MSB_FIRST=1: shift left, insert at LSB.
  - MSB_FIRST=0: shift right, insert at MSB.
- Word complete: on the edge that samples bit WIDTH-1, the assembled word (including that bit) is pushed and the bit counter returns to 0.
  - Latency: pdo_valid=1 and pdo_data valid in the cycle after that edge.
- FIFO:
  - Pop on pdo_valid & pdo_ready.
  - pdo_data holds the head word and is stable while pdo_valid=1 and pdo_ready=0.
  - Push and pop in the same cycle: level unchanged, data order preserved.
  - Full with push and no pop: word dropped, overflow set; frame_words does not increment.
  - Full with simultaneous push and pop: push accepted, no overflow.
  - Empty with pdo_ready=1: no effect.
- Frame control: a simple two-state FSM, IDLE <-> ACTIVE.
  - IDLE -> ACTIVE on cs=1: frame_words cleared to 0 on that edge; that same edge also captures bit 0.
  - ACTIVE -> IDLE on cs=0:
    - Bit counter = 0: frame_done pulses for one cycle.
    - Bit counter != 0: partial bits are discarded, partial_err pulses, bit counter resets, no push.
- frame_words increments per accepted word and saturates at 2^CNT_W-1. It holds after the frame ends until the next frame starts.
- Overflow clear: overflow clears on ovf_clr=1. If a drop occurs in the same cycle, the set wins.
- Reset mid-frame or mid-word: everything is discarded immediately; no pulses are generated.

Optional Feature:
- Macro: SIPO_STREAM_PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit, so the bit counter runs 0..WIDTH.
  - On the parity-bit edge, the word is pushed only if XOR(data, parity)=0.
  - Otherwise the word is dropped, parity_err pulses for one cycle, and frame_words does not increment.
  - cs falling after the data bits but before the parity bit counts as a partial word.
  - pdo_valid latency is measured from the parity-bit edge.
- Undefined: the parity logic is absent, parity_err is tied to 0, and words are WIDTH bits exactly.

Test Plan:
- WIDTH=32, MSB_FIRST=1: one frame carrying 0xDEADBEEF then 0x01234567, pdo_ready=1 -> pdo_data yields 0xDEADBEEF then 0x01234567, each valid 1 cycle after its last bit; frame_done pulses once; frame_words=2.
- MSB_FIRST=0: send bits of 0x0000_0001 MSB-first on the wire -> pdo_data=0x8000_0000.
- cs dropped after 20 of 32 bits -> partial_err one pulse, no push, fifo_level stays 0; the next full frame word is received intact.
- DEPTH=4, pdo_ready=0: send 5 words -> fifo_level=4, overflow=1, frame_words=4; drain yields the first 4 words in order; ovf_clr -> overflow=0.
- FIFO full, 5th word's last bit coincides with pdo_ready=1 -> no overflow, fifo_level stays 4, word 5 appears last.
- SIPO_STREAM_PARITY_EN: send 0x00000003 with parity 0 (accepted), then with parity 1 -> first word pushed; second triggers a parity_err pulse with no push.
- rst_n asserted mid-word with 2 words queued -> all outputs at reset values asynchronously.
